// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared constants for the slow-signal frequency/period meter
//
// Purpose: FSM state encodings and default sizing shared by the meter, its
// interface and software-side conversion (cycles -> Hz via CLK_HZ).
// Ports: none (package).
package freq_meter_pkg;

  // FSM state encodings (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEAS = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  // Default sizing: 32-bit counters, 2 s loss-of-signal window at 50 MHz
  localparam int          DEF_CNT_W   = 32;
  localparam int unsigned DEF_TIMEOUT = 100_000_000;

  // System clock frequency, used by software to convert period to Hz
  localparam int unsigned CLK_HZ = 50_000_000;

endpackage

// File: rtl/freq_period_meter_if.sv
// rtl/freq_period_meter_if.sv - signal input and measurement result bundle
//
// Purpose: groups the measured input and the result outputs of the meter.
// Ports (signals):
//   sig_in      slow asynchronous signal under measurement
//   period      clk cycles between the last two rising edges
//   high_time   clk cycles high within that period
//   meas_valid  one-cycle strobe when period/high_time update
//   timeout     level, no rising edge seen within the timeout window
//   armed       high while the meter is in its MEASURE state
// Modports: master = the meter, slave = whoever drives sig_in and reads results.
interface freq_period_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             armed;

  modport master (
    input  sig_in,
    output period,
    output high_time,
    output meas_valid,
    output timeout,
    output armed
  );

  modport slave (
    output sig_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  timeout,
    input  armed
  );

endinterface

// File: rtl/sig_sync_edge.sv
// rtl/sig_sync_edge.sv - multi-flop synchronizer with rise/fall edge detect
//
// Purpose: brings an asynchronous level into the clk domain and produces
// one-cycle rise/fall strobes. Edge-to-edge spacing is preserved.
// Ports:
//   clk       system clock
//   rst       synchronous active-low reset
//   async_in  asynchronous input level
//   sync_out  synchronized level (last synchronizer stage)
//   rise      one cycle high on a synchronized 0->1 transition
//   fall      one cycle high on a synchronized 1->0 transition
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      sig_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~sig_d;
  assign fall     = ~sync_out & sig_d;

endmodule

// File: rtl/freq_period_meter.sv
// rtl/freq_period_meter.sv - period / high-time meter for slow signals
//
// Purpose: measures period and high time of a slow signal in clk cycles,
// strobes meas_valid once per completed period and flags loss of signal.
// Ports:
//   clk   system clock, all logic on rising edge
//   rst   synchronous active-low reset
//   bus   freq_period_meter_if.master (sig_in in; period, high_time,
//         meas_valid, timeout, armed out)
module freq_period_meter
  import freq_meter_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int          SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  freq_period_meter_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rise;
  logic             fall;
  logic             sync_level_unused;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_tmp;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             tout_q;
  logic             armed_q;

  sig_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(bus.sig_in),
    .sync_out(sync_level_unused),
    .rise    (rise),
    .fall    (fall)
  );

  // cnt counts cycles since the last rise minus one, so cnt+1 is the
  // elapsed cycle count at the current edge and never exceeds TIMEOUT.
  assign cnt_inc = cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi_tmp   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // First rise only starts the measurement; nothing to report yet.
          cnt <= '0;
          if (rise) begin
            state   <= ST_MEAS;
            armed_q <= 1'b1;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            // A rise on the last allowed cycle still counts as a valid period.
            period_q <= cnt_inc;
            high_q   <= hi_tmp;
            valid_q  <= 1'b1;
            cnt      <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_TOUT;
            tout_q  <= 1'b1;
            armed_q <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (fall) begin
              hi_tmp <= cnt_inc;
            end
          end
        end
        ST_TOUT: begin
          // Partial period before this rise is unknown, so no report.
          if (rise) begin
            state   <= ST_MEAS;
            cnt     <= '0;
            tout_q  <= 1'b0;
            armed_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          tout_q  <= 1'b0;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = valid_q;
  assign bus.timeout    = tout_q;
  assign bus.armed      = armed_q;

endmodule

// File: tb/tb_freq_period_meter.sv
// tb/tb_freq_period_meter.sv - self-checking bench for freq_period_meter
module tb_freq_period_meter;
  import freq_meter_pkg::*;

  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  freq_period_meter_if #(.CNT_W(32)) bus ();

  freq_period_meter #(
    .CNT_W      (32),
    .TIMEOUT    (TO),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: sampled 1 time unit after each rising edge.
  int          cyc = 0;
  int          n_valid = 0;
  int          last_valid_cyc = 0;
  int          prev_valid_cyc = 0;
  int          tout_rise_cyc = -1;
  bit          saw_timeout = 0;
  int          exp_period = 0;
  int          exp_high = 0;
  logic        prev_valid = 1'b0;
  logic        prev_tout = 1'b0;
  logic        prev_rst = 1'b0;
  logic [31:0] prev_period = '0;
  logic [31:0] prev_high = '0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst && prev_rst) begin
      if (bus.meas_valid) begin
        n_valid++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        check("valid_period", bus.period, exp_period);
        check("valid_high_time", bus.high_time, exp_high);
        check("valid_armed", bus.armed, 1);
        check("valid_timeout", bus.timeout, 0);
        check("valid_one_cycle", prev_valid, 0);
      end else begin
        check("hold_period", bus.period, prev_period);
        check("hold_high_time", bus.high_time, prev_high);
      end
      if (bus.timeout && !prev_tout) begin
        tout_rise_cyc = cyc;
        saw_timeout   = 1;
      end
    end
    prev_valid  = bus.meas_valid;
    prev_tout   = bus.timeout;
    prev_rst    = rst;
    prev_period = bus.period;
    prev_high   = bus.high_time;
  end

  // Stimulus helpers: all driving happens on falling edges.
  task automatic drive(input bit lvl, input int n);
    bus.sig_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    bus.sig_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    int hi;
    int lo;
    int nper;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs[7];
  int   nv;

  initial begin
    vecs[0] = '{hi: 5,  lo: 5,  nper: 4, exp_period: 10, exp_high: 5};
    vecs[1] = '{hi: 3,  lo: 4,  nper: 4, exp_period: 7,  exp_high: 3};
    vecs[2] = '{hi: 1,  lo: 1,  nper: 6, exp_period: 2,  exp_high: 1};
    vecs[3] = '{hi: 10, lo: 10, nper: 3, exp_period: 20, exp_high: 10};
    vecs[4] = '{hi: 32, lo: 32, nper: 2, exp_period: 64, exp_high: 32};
    vecs[5] = '{hi: 1,  lo: 63, nper: 2, exp_period: 64, exp_high: 1};
    vecs[6] = '{hi: 2,  lo: 5,  nper: 3, exp_period: 7,  exp_high: 2};

    bus.sig_in = 1'b0;
    rst        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_period", bus.period, 0);
    check("reset_high_time", bus.high_time, 0);
    check("reset_meas_valid", bus.meas_valid, 0);
    check("reset_timeout", bus.timeout, 0);
    check("reset_armed", bus.armed, 0);
    rst = 1'b1;

    // Table-driven periodic patterns; one trailing rise closes the last period.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      saw_timeout = 0;
      exp_period  = vecs[i].exp_period;
      exp_high    = vecs[i].exp_high;
      nv          = n_valid;
      for (int p = 0; p < vecs[i].nper; p++) begin
        drive(1'b1, vecs[i].hi);
        drive(1'b0, vecs[i].lo);
      end
      drive(1'b1, 6);
      check($sformatf("vec%0d_valid_count", i), n_valid - nv, vecs[i].nper);
      check($sformatf("vec%0d_no_timeout", i), saw_timeout, 0);
      check($sformatf("vec%0d_armed", i), bus.armed, 1);
    end

    // Chain check: divide-by-20 model (high 10 / low 10) driving sig_in.
    do_reset();
    exp_period = 20;
    exp_high   = 10;
    nv         = n_valid;
    for (int c = 0; c < 100; c++) begin
      bus.sig_in = ((c % 20) < 10);
      @(negedge clk);
    end
    check("chain_valid_count", n_valid - nv, 4);
    check("chain_valid_spacing", last_valid_cyc - prev_valid_cyc, 20);

    // Rises 65 apart: timeout 64 cycles after the last reported rise.
    do_reset();
    exp_period = 10;
    exp_high   = 5;
    drive(1'b1, 5); drive(1'b0, 5);
    drive(1'b1, 5); drive(1'b0, 5);
    drive(1'b1, 5);
    nv            = n_valid;
    tout_rise_cyc = -1;
    drive(1'b0, 60);
    drive(1'b1, 5);
    check("t65_timeout_delay", tout_rise_cyc - last_valid_cyc, TO);
    check("t65_no_valid", n_valid - nv, 0);
    check("t65_timeout_cleared", bus.timeout, 0);
    check("t65_rearmed", bus.armed, 1);
    check("t65_period_held", bus.period, 10);
    drive(1'b0, 5);
    drive(1'b1, 5);
    check("t65_next_valid", n_valid - nv, 1);

    // Signal stuck high after a rise.
    do_reset();
    exp_period = 10;
    exp_high   = 5;
    nv         = n_valid;
    tout_rise_cyc = -1;
    drive(1'b1, 5); drive(1'b0, 5);
    drive(1'b1, 5); drive(1'b0, 5);
    drive(1'b1, 80);
    check("stuck_valid_count", n_valid - nv, 2);
    check("stuck_timeout", bus.timeout, 1);
    check("stuck_timeout_delay", tout_rise_cyc - last_valid_cyc, TO);
    check("stuck_armed", bus.armed, 0);
    check("stuck_period", bus.period, 10);
    check("stuck_high_time", bus.high_time, 5);
    nv = n_valid;
    drive(1'b0, 5);
    drive(1'b1, 5); drive(1'b0, 5);
    check("stuck_clear_timeout", bus.timeout, 0);
    check("stuck_clear_no_valid", n_valid - nv, 0);
    check("stuck_clear_armed", bus.armed, 1);
    drive(1'b1, 5); drive(1'b0, 2);
    check("stuck_resume_valid", n_valid - nv, 1);

    // Reset pulse while cnt is around 30.
    do_reset();
    exp_period = 60;
    exp_high   = 20;
    drive(1'b1, 20); drive(1'b0, 40);
    drive(1'b1, 20); drive(1'b0, 13);
    rst = 1'b0;
    @(negedge clk);
    check("rmid_period", bus.period, 0);
    check("rmid_high_time", bus.high_time, 0);
    check("rmid_meas_valid", bus.meas_valid, 0);
    check("rmid_timeout", bus.timeout, 0);
    check("rmid_armed", bus.armed, 0);
    rst = 1'b1;
    nv  = n_valid;
    drive(1'b0, 26);
    drive(1'b1, 20); drive(1'b0, 40);
    check("rmid_first_rise_silent", n_valid - nv, 0);
    drive(1'b1, 6);
    check("rmid_second_rise_valid", n_valid - nv, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_period_meter.md
Name: freq_period_meter

Overview:
- Receive-side counterpart to the clock-divider chain: it measures a slow external or divided signal rather than generating one.
- Samples the slow signal `sig_in` (e.g. 3 Hz / 1.5 Hz divider output) against the 50 MHz system clock.
- Reports period and high time in clk cycles, with a one-cycle valid strobe per completed period.
- Flags loss of signal via a timeout.
- Used on-board to check divider outputs and to measure unknown slow inputs.

Parameters:
- CNT_W, 32, width of counters and result outputs.
- TIMEOUT, 100_000_000, clk cycles without a rising edge before timeout (2 s at 50 MHz). Must satisfy 2 <= TIMEOUT < 2^CNT_W.
- SYNC_STAGES, 2, synchronizer flops on `sig_in` (>= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- sig_in  input  1  asynchronous slow signal under measurement
- period  output  CNT_W  clk cycles between last two rising edges
- high_time  output  CNT_W  clk cycles high within that period
- meas_valid  output  1  one-cycle pulse when period/high_time update
- timeout  output  1  level; no rising edge for TIMEOUT cycles
- armed  output  1  high in MEASURE state

Behaviour:
- **Reset.** rst=0 at a clk edge clears:
  - synchronizer and edge-detect flops;
  - cnt, hi_tmp, period, high_time, meas_valid, timeout, armed (all to 0);
  - FSM to IDLE.
  - Reset mid-measurement discards the partial count. The first rising edge after reset is never reported.
- **Sync/edge detect.**
  - `sig_in` passes through SYNC_STAGES flops giving `sig_s`, then one more flop giving `sig_d`.
  - rise = sig_s & ~sig_d; fall = ~sig_s & sig_d, each one cycle wide.
  - Latency from a `sig_in` transition to rise/fall is SYNC_STAGES+1 clks. Edge-to-edge spacing is preserved.
- **FSM states:** IDLE, MEASURE, TOUT.
  - IDLE: cnt held 0. rise -> MEASURE, cnt<=0. No valid.
  - MEASURE: each cycle without rise: cnt<=cnt+1.
    - fall: hi_tmp<=cnt+1.
    - rise: period<=cnt+1, high_time<=hi_tmp, meas_valid<=1 for exactly one cycle, cnt<=0, remain in MEASURE.
    - No rise while cnt==TIMEOUT-1 -> TOUT, timeout<=1.
    - A rise on the cycle cnt==TIMEOUT-1 wins: a valid measurement of TIMEOUT is reported, no timeout.
  - TOUT: cnt held. period/high_time hold their last values. rise -> MEASURE, cnt<=0, timeout<=0, no valid (the partial period is unknown).
- **Outputs.** period/high_time change only together with meas_valid and are stable otherwise.
- **Width rules.**
  - cnt+1 never exceeds TIMEOUT, so no wrap is possible.
  - high_time < period for any reported pair.
  - Minimum measurable period is 2 (sig toggling every clk): reports period=2, high_time=1.
- **Signal stuck high.** Handled by timeout (no rise). A fall with no subsequent rise leaves hi_tmp unused until the next rise.
- **armed** = (state==MEASURE), registered.

Decomposition:
- Shared package `freq_meter_pkg`:
  - FSM state localparams ST_IDLE=2'd0, ST_MEAS=2'd1, ST_TOUT=2'd2;
  - default CNT_W/TIMEOUT constants;
  - CLK_HZ=50_000_000 for software conversion.
- One sub-module: `sig_sync_edge` (params SYNC_STAGES). Ports: clk, rst, async_in, sync_out, rise, fall.
- FSM, counters and result registers live in the top.

Test Plan:
- All scenarios use TIMEOUT=64, SYNC_STAGES=2.
- **Basic square wave.** `sig_in` high 5 / low 5 clks, repeating, from reset release -> no valid on first rise. On each later rise: meas_valid one cycle, period=10, high_time=5, armed=1, timeout=0.
- **Asymmetric duty and minimum period.**
  - high 3 / low 4 -> period=7, high_time=3.
  - toggling every clk -> period=2, high_time=1 on every rise after the first.
- **Timeout boundary.**
  - rises exactly 64 clks apart -> period=64 valid, timeout stays 0.
  - rises 65 apart -> timeout=1 on cycle 64 after the last rise, no valid, period holds its previous value.
  - next rise -> timeout=0, no valid; following rise 10 later -> period=10.
- **Signal stuck.**
  - `sig_in` held high after a rise -> timeout after 64 clks, outputs frozen.
  - release and resume 5/5 -> first rise clears timeout, second gives period=10, high_time=5.
- **Reset mid-measurement.** rst=0 for 1 clk while cnt=30 -> all outputs 0, state IDLE. The next rise gives no valid; the second rise after it gives a correct period.
- **Chain check.** Drive `sig_in` from a divider model producing period 20 (high 10) -> steady period=20, high_time=10, exactly one meas_valid per 20 clks.
